// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit with HI/LO registers for a multicycle MIPS datapath.
// MULT is 32-step shift-add and DIV is 32-step restoring division, both on magnitudes with signs fixed up at FINISH.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t      state, state_next;
    logic [32:0] mag_a, mag_b;
    logic [32:0] operand;      // |a| for multiply, |b| for divide
    logic [63:0] acc;
    logic [4:0]  cnt;
    logic        is_div, neg_res, neg_rem, dz_pending;

    logic [32:0] mult_sum;
    logic [63:0] mult_next;
    logic [32:0] div_shift, div_diff;
    logic [63:0] div_next;
    logic [63:0] prod;
    logic [31:0] quot, rem;

    // 33-bit magnitudes keep |-2^31| exact.
    assign mag_a = a[31] ? 33'd0 - {a[31], a} : {1'b0, a};
    assign mag_b = b[31] ? 33'd0 - {b[31], b} : {1'b0, b};

    assign mult_sum  = {1'b0, acc[63:32]} + (acc[0] ? operand : 33'd0);
    assign mult_next = {mult_sum, acc[31:1]};

    assign div_shift = {acc[63:32], acc[31]};
    assign div_diff  = div_shift - operand;
    assign div_next  = (div_shift >= operand) ? {div_diff[31:0], acc[30:0], 1'b1}
                                              : {div_shift[31:0], acc[30:0], 1'b0};

    assign prod = neg_res ? 64'd0 - acc : acc;
    assign quot = neg_res ? 32'd0 - acc[31:0] : acc[31:0];
    assign rem  = neg_rem ? 32'd0 - acc[63:32] : acc[63:32];

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_mult)     state_next = MULT;
                else if (start_div) state_next = (b == 32'd0) ? FINISH : DIV;
            end
            MULT, DIV: begin
                if (cnt == 5'd31) state_next = FINISH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every register here updates with <= so all of them see the pre-edge values of acc, cnt and state.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc        <= '0;
            operand    <= '0;
            cnt        <= '0;
            is_div     <= 1'b0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            dz_pending <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (start_mult || start_div) begin
                        cnt        <= '0;
                        div_zero   <= 1'b0;
                        is_div     <= !start_mult;
                        neg_res    <= a[31] ^ b[31];
                        neg_rem    <= a[31];
                        dz_pending <= !start_mult && (b == 32'd0);
                        if (start_mult) begin
                            operand <= mag_a;
                            acc     <= {32'd0, mag_b[31:0]};
                        end else begin
                            operand <= mag_b;
                            acc     <= {32'd0, mag_a[31:0]};
                        end
                    end
                end
                MULT: begin
                    acc <= mult_next;
                    cnt <= cnt + 5'd1;
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 5'd1;
                end
                FINISH: begin
                    if (dz_pending) begin
                        div_zero <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem;
                        lo <= quot;
                    end else begin
                        hi <= prod[63:32];
                        lo <= prod[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
